// File: rtl/chacha_aead_pkg.sv
// Shared widths, FSM state encoding and byte-count helper for the ChaCha20 AEAD payload path.
package chacha_aead_pkg;

  localparam int DATA_W = 128;
  localparam int KS_W   = 512;
  localparam int CNT_W  = 64;
  localparam int LANES  = KS_W / DATA_W;
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/ks_lane_buf.sv
// One keystream block buffer: holds a 512-bit block, a valid flag and the index of
// the next unconsumed 128-bit lane. clear beats load, load beats consume.
module ks_lane_buf
  import chacha_aead_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [KS_W-1:0]   load_data,
  input  logic              consume,
  output logic              valid,
  output logic [1:0]        lane,
  output logic [DATA_W-1:0] lane_data
);

  logic [KS_W-1:0] block_q;
  logic            valid_q;
  logic [1:0]      lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
      valid_q <= 1'b0;
      lane_q  <= 2'd0;
    end else if (clear) begin
      valid_q <= 1'b0;
      lane_q  <= 2'd0;
    end else if (load) begin
      block_q <= load_data;
      valid_q <= 1'b1;
      lane_q  <= 2'd0;
    end else if (consume && valid_q) begin
      lane_q <= lane_q + 2'd1;
      // Last lane used up: the block is spent and must not be reused.
      if (lane_q == 2'(LANES - 1)) valid_q <= 1'b0;
    end
  end

  always_comb begin
    lane_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == 2'(k)) lane_data = block_q[k*DATA_W +: DATA_W];
    end
  end

  assign valid = valid_q;
  assign lane  = lane_q;

endmodule

// File: rtl/chacha_ks_xor_stage.sv
// Keystream XOR stage: applies 128-bit keystream lanes to payload beats under a byte
// keep mask and counts payload bytes. Define KS_PREFETCH_EN for a ping-pong keystream buffer.
module chacha_ks_xor_stage
  import chacha_aead_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ks_req,
  input  logic              ks_valid,
  input  logic [KS_W-1:0]   ks_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic [CNT_W-1:0]  ct_bytes,
  output logic              ct_bytes_valid,
  output state_e            dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
  // valid never waits on ready, and a held valid keeps its payload stable until taken.

  state_e            state_q, state_d;
  logic              buf_valid;
  logic [1:0]        buf_lane;
  logic [DATA_W-1:0] lane_data;
  logic              ks_load;
  logic              next_block_ready;
  logic              accept, flush, lane_take, emit;
  logic [DATA_W-1:0] masked;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [KEEP_W-1:0] out_keep_q;
  logic              out_last_q;
  logic [CNT_W-1:0]  ct_q;

  assign in_ready  = (state_q == RUN) && buf_valid && !start && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign flush     = accept && in_last;
  // Empty-keep beats carry no payload, so they never burn keystream.
  assign lane_take = accept && (in_keep != '0);
  assign emit      = accept && ((in_keep != '0) || in_last);

`ifdef KS_PREFETCH_EN
  logic              rd_sel, alt_sel, ld_sel;
  logic [1:0]        b_valid, b_load, b_consume;
  logic [1:0][1:0]   b_lane;
  logic [1:0][DATA_W-1:0] b_data;

  assign alt_sel          = ~rd_sel;
  assign ld_sel           = b_valid[rd_sel] ? alt_sel : rd_sel;
  assign ks_req           = ((state_q == REQ) || (state_q == RUN)) && !(&b_valid);
  assign ks_load          = ks_req && ks_valid && !start && !flush;
  assign next_block_ready = b_valid[alt_sel] || (ks_load && (ld_sel == alt_sel));
  assign buf_valid        = b_valid[rd_sel];
  assign buf_lane         = b_lane[rd_sel];
  assign lane_data        = b_data[rd_sel];

  for (genvar g = 0; g < 2; g++) begin : g_buf
    assign b_load[g]    = ks_load && (ld_sel == 1'(g));
    assign b_consume[g] = lane_take && (rd_sel == 1'(g));

    ks_lane_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start || flush),
      .load      (b_load[g]),
      .load_data (ks_data),
      .consume   (b_consume[g]),
      .valid     (b_valid[g]),
      .lane      (b_lane[g]),
      .lane_data (b_data[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sel <= 1'b0;
    else if (start || flush) rd_sel <= 1'b0;
    else if (lane_take && (buf_lane == 2'(LANES - 1))) rd_sel <= alt_sel;
  end
`else
  assign ks_req           = (state_q == REQ);
  assign ks_load          = ks_req && ks_valid && !start;
  assign next_block_ready = 1'b0;

  ks_lane_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start || flush),
    .load      (ks_load),
    .load_data (ks_data),
    .consume   (lane_take),
    .valid     (buf_valid),
    .lane      (buf_lane),
    .lane_data (lane_data)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = REQ;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        REQ:  if (ks_load) state_d = RUN;
        RUN: begin
          if (flush) state_d = DONE;
          else if (lane_take && (buf_lane == 2'(LANES - 1)))
            state_d = next_block_ready ? RUN : REQ;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (in_keep[i]) masked[8*i +: 8] = in_data[8*i +: 8] ^ lane_data[8*i +: 8];
    end
  end

  // Output register: data only moves on emit, so out_ready never reaches out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (start) begin
      out_valid_q <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_data_q  <= masked;
      out_keep_q  <= in_keep;
      out_last_q  <= in_last;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ct_q <= '0;
    else if (start)  ct_q <= '0;
    else if (accept) ct_q <= ct_q + CNT_W'(popcount16(in_keep));
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_keep       = out_keep_q;
  assign out_last       = out_last_q;
  assign ct_bytes       = ct_q;
  assign ct_bytes_valid = (state_q == DONE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_chacha_ks_xor_stage.sv
// Directed bench for chacha_ks_xor_stage; expectations adapt to KS_PREFETCH_EN timing.
module tb_chacha_ks_xor_stage;
  import chacha_aead_pkg::*;

  localparam int EW = DATA_W + KEEP_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              ks_req;
  logic              ks_valid;
  logic [KS_W-1:0]   ks_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [KEEP_W-1:0] in_keep;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              out_last;
  logic [CNT_W-1:0]  ct_bytes;
  logic              ct_bytes_valid;
  state_e            dbg_state;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            ks_eps;
  logic          ks_req_prev = 1'b0;
  int            ct_pulses;
  logic [CNT_W-1:0] ct_seen;
  int            last_wait;
  logic          ks_auto;
  logic          ks_force;

  chacha_ks_xor_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .ks_req         (ks_req),
    .ks_valid       (ks_valid),
    .ks_data        (ks_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_keep        (in_keep),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_keep       (out_keep),
    .out_last       (out_last),
    .ct_bytes       (ct_bytes),
    .ct_bytes_valid (ct_bytes_valid),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // keystream responder: answers a request with a one-cycle ks_valid pulse
  always @(posedge clk) begin
    #2;
    ks_valid = (ks_auto && ks_req && !ks_valid) || ks_force;
  end

  // monitors
  always @(negedge clk) begin
    if (out_valid && out_ready) obs_q.push_back({out_data, out_keep, out_last});
    if (ks_req && !ks_req_prev) ks_eps++;
    ks_req_prev = ks_req;
    if (ct_bytes_valid) begin
      ct_pulses++;
      ct_seen = ct_bytes;
    end
  end

  function automatic logic [KS_W-1:0] make_block(input logic [7:0] base);
    logic [KS_W-1:0] b;
    for (int k = 0; k < LANES; k++)
      for (int i = 0; i < KEEP_W; i++) b[DATA_W*k + 8*i +: 8] = base + 8'(k + 1);
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] lane_of(input logic [7:0] base, input int k);
    logic [7:0] v;
    v = base + 8'(k + 1);
    return {KEEP_W{v}};
  endfunction

  // driver tasks (enter and leave 1 time unit after a rising edge)
  task automatic start_msg(input logic [7:0] base);
    ks_data = make_block(base);
    obs_q.delete();
    exp_q.delete();
    ks_eps    = 0;
    ct_pulses = 0;
    ct_seen   = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    last_wait = waited;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL beat_accept in_ready=%b want=1 after %0d cycles", in_ready, waited);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_keep  = '0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ks_auto = 1'b1; ks_force = 1'b0; ks_data = '0;
    in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b1;
    ct_pulses = 0; ks_eps = 0;
    repeat (3) @(negedge clk);
    total += 8;
    if (ks_req !== 1'b0)         begin bad++; $display("FAIL reset_ks_req got=%b want=0", ks_req); end
    if (in_ready !== 1'b0)       begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    if (out_valid !== 1'b0)      begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (out_data !== '0)         begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    if (out_keep !== '0 || out_last !== 1'b0) begin bad++; $display("FAIL reset_keep_last got=%h/%b want=0/0", out_keep, out_last); end
    if (ct_bytes !== '0)         begin bad++; $display("FAIL reset_ct_bytes got=%0d want=0", ct_bytes); end
    if (ct_bytes_valid !== 1'b0) begin bad++; $display("FAIL reset_ct_valid got=%b want=0", ct_bytes_valid); end
    if (dbg_state !== IDLE)      begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // stray keystream while nothing is requested must be ignored
    ks_force = 1'b1;
    idle_cycles(1);
    ks_force = 1'b0;
    @(negedge clk);
    total += 2;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL idle_ks_ignore state=%0d want=%0d", dbg_state, IDLE); end
    if (in_ready !== 1'b0)  begin bad++; $display("FAIL idle_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    start_msg(8'h00);
    send_beat('0, 16'hFFFF, 1'b1);
    exp_q.push_back({{KEEP_W{8'h01}}, 16'hFFFF, 1'b1});
    idle_cycles(4);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total += 4;
    if (ct_seen !== 64'd16) begin bad++; $display("FAIL single_ct got=%0d want=16", ct_seen); end
    if (ct_pulses != 1)     begin bad++; $display("FAIL single_ct_pulses got=%0d want=1", ct_pulses); end
    if (ks_eps != 1)        begin bad++; $display("FAIL single_ks_eps got=%0d want=1", ks_eps); end
    if (ct_bytes !== 64'd16) begin bad++; $display("FAIL single_ct_hold got=%0d want=16", ct_bytes); end
  endtask

  task automatic test_back_to_back();
    int wait_sum;
    int wait5;
    wait_sum = 0;
    wait5    = 0;
    start_msg(8'h00);
    for (int b = 0; b < 8; b++) begin
      send_beat('0, 16'hFFFF, (b == 7));
      if (b > 0) wait_sum += last_wait;
      if (b == 4) wait5 = last_wait;
      exp_q.push_back({lane_of(8'h00, b % 4), 16'hFFFF, (b == 7)});
    end
    idle_cycles(4);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (ct_seen !== 64'd128) begin bad++; $display("FAIL b2b_ct got=%0d want=128", ct_seen); end
`ifdef KS_PREFETCH_EN
    total++;
    if (wait_sum != 0) begin bad++; $display("FAIL b2b_stall got=%0d want=0", wait_sum); end
`else
    total += 2;
    if (wait5 < 1)   begin bad++; $display("FAIL b2b_bubble got=%0d want>=1", wait5); end
    if (ks_eps != 2) begin bad++; $display("FAIL b2b_ks_eps got=%0d want=2", ks_eps); end
`endif
  endtask

  task automatic test_partial();
    start_msg(8'h00);
    send_beat({KEEP_W{8'hFF}}, 16'hFFFF, 1'b0);
    send_beat({KEEP_W{8'hFF}}, 16'h0007, 1'b1);
    exp_q.push_back({{KEEP_W{8'hFE}}, 16'hFFFF, 1'b0});
    exp_q.push_back({128'h0000_0000_0000_0000_0000_0000_00FD_FDFD, 16'h0007, 1'b1});
    idle_cycles(6);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL partial_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL partial_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total += 3;
    if (ct_seen !== 64'd19) begin bad++; $display("FAIL partial_ct got=%0d want=19", ct_seen); end
    if (ks_eps != 1)        begin bad++; $display("FAIL partial_ks_eps got=%0d want=1", ks_eps); end
    if (ks_req !== 1'b0)    begin bad++; $display("FAIL partial_ks_req got=%b want=0", ks_req); end
  endtask

  task automatic test_keep_zero();
    start_msg(8'h00);
    send_beat('0, 16'hFFFF, 1'b0);
    send_beat({KEEP_W{8'h55}}, 16'h0000, 1'b0);
    send_beat('0, 16'hFFFF, 1'b0);
    send_beat({KEEP_W{8'h55}}, 16'h0000, 1'b1);
    exp_q.push_back({lane_of(8'h00, 0), 16'hFFFF, 1'b0});
    exp_q.push_back({lane_of(8'h00, 1), 16'hFFFF, 1'b0});
    exp_q.push_back({{DATA_W{1'b0}}, 16'h0000, 1'b1});
    idle_cycles(4);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL keep0_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL keep0_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total += 2;
    if (ct_seen !== 64'd32) begin bad++; $display("FAIL keep0_ct got=%0d want=32", ct_seen); end
    if (ct_pulses != 1)     begin bad++; $display("FAIL keep0_ct_pulses got=%0d want=1", ct_pulses); end
  endtask

  task automatic test_backpressure();
    start_msg(8'h00);
    out_ready = 1'b0;
    send_beat('0, 16'hFFFF, 1'b0);
    in_valid = 1'b1;
    in_data  = {KEEP_W{8'hA0}};
    in_keep  = 16'hFFFF;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
      if (out_data !== lane_of(8'h00, 0)) begin bad++; $display("FAIL bp_out_data got=%h want=%h", out_data, lane_of(8'h00, 0)); end
      if (in_ready !== 1'b0)  begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat({KEEP_W{8'hA0}}, 16'hFFFF, 1'b0);
    send_beat('0, 16'hFFFF, 1'b1);
    exp_q.push_back({lane_of(8'h00, 0), 16'hFFFF, 1'b0});
    exp_q.push_back({{KEEP_W{8'hA2}}, 16'hFFFF, 1'b0});
    exp_q.push_back({lane_of(8'h00, 2), 16'hFFFF, 1'b1});
    idle_cycles(4);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (ct_seen !== 64'd48) begin bad++; $display("FAIL bp_ct got=%0d want=48", ct_seen); end
  endtask

  task automatic test_abort();
    start_msg(8'h00);
    send_beat('0, 16'hFFFF, 1'b0);
    idle_cycles(1);
    out_ready = 1'b0;
    send_beat('0, 16'hFFFF, 1'b0);
    @(negedge clk);
    total += 2;
    if (ct_bytes !== 64'd32) begin bad++; $display("FAIL abort_ct_before got=%0d want=32", ct_bytes); end
    if (out_valid !== 1'b1)  begin bad++; $display("FAIL abort_pending got=%b want=1", out_valid); end
    @(posedge clk); #1;
    ks_data = make_block(8'h10);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0)  begin bad++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
    if (ks_req !== 1'b1)     begin bad++; $display("FAIL abort_ks_req got=%b want=1", ks_req); end
    if (ct_bytes !== '0)     begin bad++; $display("FAIL abort_ct got=%0d want=0", ct_bytes); end
    if (dbg_state !== REQ)   begin bad++; $display("FAIL abort_state got=%0d want=%0d", dbg_state, REQ); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat('0, 16'hFFFF, 1'b1);
    exp_q.push_back({lane_of(8'h00, 0), 16'hFFFF, 1'b0});
    exp_q.push_back({lane_of(8'h10, 0), 16'hFFFF, 1'b1});
    idle_cycles(4);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL abort_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (ct_seen !== 64'd16) begin bad++; $display("FAIL abort_ct_after got=%0d want=16", ct_seen); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_partial();
    test_keep_zero();
    test_backpressure();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chacha_ks_xor_stage.md
Name: chacha_ks_xor_stage

Overview:
Payload encrypt/decrypt stage downstream of the ChaCha20 keystream generator and alongside chacha_poly1305_adapter. It holds one 512-bit keystream block and splits it into four 128-bit lanes. Each lane is XORed with one 128-bit payload beat under a byte keep mask. The stage emits ciphertext or plaintext beats and a final payload byte count, which the len_block builder uses.

Parameters:
DATA_W, 128, payload beat width (bits)
KS_W, 512, keystream block width; lanes = KS_W/DATA_W = 4
CNT_W, 64, payload byte counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin a new message, aborting any message in progress
ks_req  out  1  level request for a new keystream block
ks_valid  in  1  keystream block present; captured only while ks_req=1
ks_data  in  KS_W  keystream block; lane k = bits [128k+127:128k]
in_valid  in  1  payload beat valid
in_ready  out  1  payload beat accepted when in_valid & in_ready
in_data  in  DATA_W  payload beat; byte i = bits [8i+7:8i]
in_keep  in  DATA_W/8  byte enables, contiguous and low-aligned
in_last  in  1  final beat of the message
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
out_data  out  DATA_W  in_data XOR lane; bytes with keep=0 are forced to 0
out_keep  out  DATA_W/8  registered copy of in_keep
out_last  out  1  registered copy of in_last
ct_bytes  out  CNT_W  total bytes in the message
ct_bytes_valid  out  1  one-cycle pulse; ct_bytes is stable until the next start

Behaviour:
- Reset: every output is 0, the FSM is in IDLE and the lane index is 0.
- FSM states:
  - IDLE: ks_req=0, in_ready=0.
  - start → REQ.
  - REQ: ks_req=1. ks_valid captures ks_data, sets lane=0 → RUN. ks_valid while ks_req=0 is ignored.
  - RUN: in_ready = !out_valid | out_ready.
  - DONE: entered the cycle after the last beat is accepted; ct_bytes_valid pulses once, then → IDLE.
- Beat accept in RUN:
  - The output register loads on the next edge (1-cycle latency).
  - The beat consumes lane `lane`, and the lane index increments.
  - After lane 3 is consumed, the buffer is empty → REQ (ks_req asserts the next cycle, giving a bubble of at least 1 cycle).
- Partial beat (keep ≠ all-ones): consumes a whole lane. The unused keystream bytes are discarded and never reused.
- keep=0 beat:
  - Legal only with in_last=1. It is accepted, does not consume a lane, and emits out_keep=0, out_last=1.
  - keep=0 with in_last=0 is accepted and dropped: no output beat, no lane consumed.
- Byte counter:
  - Cleared on start; adds popcount(in_keep) on each accepted beat; wraps modulo 2^CNT_W.
  - ct_bytes is updated in the same edge as the last beat's accept, so the count includes that beat.
- in_last: the remaining lanes are discarded. No further ks_req is issued until the next start.
- Output handshake: out_valid is held, with data stable, until out_ready. No combinational path from out_ready to out_data.
- start at any time: clears out_valid, the buffer, the counter and the lane index → REQ next cycle. start has priority over a simultaneous beat accept or ks_valid.
- Backpressure in REQ:
  - in_ready=0.
  - A pending out_valid still drains while out_ready=1.

Optional Feature:
KS_PREFETCH_EN
- Defined:
  - A second keystream buffer (ping-pong) is added.
  - ks_req asserts whenever either buffer is empty and the message has not ended.
  - Lane 3 to lane 0 crossover incurs no bubble if the next block arrived in time.
  - On in_last or start, both buffers are invalidated.
- Undefined: a single buffer with the bubble behaviour described above.
- Byte count and output values are identical in both builds; only timing differs.

Decomposition:
- Package chacha_aead_pkg holds:
  - DATA_W, KS_W, CNT_W and LANES.
  - The FSM state enum {IDLE, REQ, RUN, DONE}.
  - The popcount16 function.
- Sub-module ks_lane_buf: holds a 512-bit block, a valid flag and a 2-bit lane index, and provides lane-select output, load and consume.
  - Instantiated once, or twice under KS_PREFETCH_EN.
- The top module holds the FSM, XOR/mask, output register and counter.

Test Plan:
- Single-lane block and one full beat:
  - Stimulus: ks_data with every byte of lane k = 8'h(k+1); start; one beat data=128'h0, keep=FFFF, last=1.
  - Response: out_data=128'h0101…01, out_last=1, ct_bytes=16, exactly one ks_req episode.
- Four full beats:
  - Stimulus: data=0, out_ready=1.
  - Response: outputs are lanes 1,2,3,4; a second ks_req asserts after beat 4 (single-buffer: in_ready low for at least 1 cycle).
- Partial final beat:
  - Stimulus: beat 1 data=all-FF, keep=FFFF; beat 2 data=all-FF, keep=0007, last=1.
  - Response: beat 2 out_data=128'h…0000FDFDFD (upper 13 bytes zero); ct_bytes=19; no further ks_req.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles during RUN.
  - Response: out_data stays stable, in_ready=0, no lane skipped; out_ready=1 resumes in order.
- Abort:
  - Stimulus: start pulse mid-message after 2 beats.
  - Response: out_valid=0 next cycle, ks_req=1, ct_bytes reset to 0, and the next beat uses lane 0 of the new block.
- Prefetch (KS_PREFETCH_EN):
  - Stimulus: 8 full beats with ks_valid returned 1 cycle after each request.
  - Response: in_ready never deasserts between beats; outputs are identical to the non-prefetch build.
